// File: rtl/alu_mdu_seq_pkg.sv
// Shared opcode/funct encodings and the multiply/divide sequencer states
// for the sequential ALU with iterative multiply/divide.
package alu_pkg;

    // Opcode field op[6:3]
    localparam logic [3:0] OP_ALU0 = 4'b0000;  // unsigned group
    localparam logic [3:0] OP_ALU1 = 4'b0001;  // signed group
    localparam logic [3:0] OP_ALU2 = 4'b0010;  // shift/rotate group
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_SLTI = 4'b0100;
    localparam logic [3:0] OP_BNEQ = 4'b0101;
    localparam logic [3:0] OP_BGTZ = 4'b0110;
    localparam logic [3:0] OP_LH   = 4'b1000;  // address add, falls into a + b
    localparam logic [3:0] OP_SH   = 4'b1001;  // address add, falls into a + b

    // ALU0 funct
    localparam logic [2:0] F0_ADDU  = 3'b000;
    localparam logic [2:0] F0_SUBU  = 3'b001;
    localparam logic [2:0] F0_MULTU = 3'b010;
    localparam logic [2:0] F0_DIVU  = 3'b011;
    localparam logic [2:0] F0_AND   = 3'b100;
    localparam logic [2:0] F0_OR    = 3'b101;
    localparam logic [2:0] F0_NOR   = 3'b110;
    localparam logic [2:0] F0_XOR   = 3'b111;

    // ALU1 funct
    localparam logic [2:0] F1_ADD   = 3'b000;
    localparam logic [2:0] F1_SUB   = 3'b001;
    localparam logic [2:0] F1_MULT  = 3'b010;
    localparam logic [2:0] F1_DIV   = 3'b011;
    localparam logic [2:0] F1_SLT   = 3'b100;
    localparam logic [2:0] F1_SEQ   = 3'b101;
    localparam logic [2:0] F1_SLTU  = 3'b110;
    localparam logic [2:0] F1_PASSA = 3'b111;

    // ALU2 funct
    localparam logic [2:0] F2_SHR = 3'b000;
    localparam logic [2:0] F2_SHL = 3'b001;
    localparam logic [2:0] F2_ROR = 3'b010;
    localparam logic [2:0] F2_ROL = 3'b011;
    localparam logic [2:0] F2_SRA = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle of the sequential ALU.
// Handshake: an operation is taken on a rising edge where in_valid && in_ready;
// op/a/b are only sampled on that edge. out_valid is a one-cycle pulse with no
// back-pressure: result/flags/hi/lo are updated in that cycle. state mirrors
// the multiply/divide sequencer for observation.
interface alu_mdu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero_flag;
    logic             sign_flag;
    logic             div_by_zero;
    logic             busy;
    state_t           state;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, hi, lo,
               zero_flag, sign_flag, div_by_zero, busy, state
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, hi, lo,
               zero_flag, sign_flag, div_by_zero, busy, state
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiplier / restoring divider working on magnitudes.
// IDLE -> RUN (WIDTH steps) -> FIX (sign correction, o_done) -> IDLE.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output state_t           o_state
);
    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [SHW-1:0]     r_cnt;
    logic               r_is_div;
    logic               r_neg_q;    // negate product (mult) or quotient (div)
    logic               r_neg_r;    // negate remainder: dividend was negative
    logic [WIDTH-1:0]   r_mcand;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_acc;      // product high half or partial remainder
    logic [WIDTH-1:0]   r_q;        // multiplier/product low half or quotient

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_mag_a    = (i_is_signed && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
    assign w_mag_b    = (i_is_signed && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;
    assign w_sum      = {1'b0, r_acc} + {1'b0, r_mcand & {WIDTH{r_q[0]}}};
    assign w_rem_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_mcand};
    assign w_prod     = {r_acc, r_q};
    assign w_prod_neg = ~w_prod + 1'b1;
    assign o_state    = r_state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and done strobe
    always_comb begin
        w_next = r_state;
        o_done = 1'b0;
        case (r_state)
            IDLE: if (i_start) w_next = RUN;
            RUN:  if (r_cnt == SHW'(WIDTH - 1)) w_next = FIX;
            FIX: begin
                w_next = IDLE;
                o_done = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand load and one shift-add / restoring step per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_cnt    <= '0;
                    r_is_div <= i_is_div;
                    r_neg_q  <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    r_neg_r  <= i_is_signed && i_a[WIDTH-1];
                    r_mcand  <= w_mag_b;
                    r_acc    <= '0;
                    r_q      <= w_mag_a;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        // Borrow means the divisor did not fit: keep the shifted remainder.
                        r_acc <= w_diff[WIDTH+1] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH+1]};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign-corrected hi/lo presented during FIX
    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            o_lo = r_neg_q ? (~r_q + 1'b1) : r_q;
            o_hi = r_neg_r ? (~r_acc + 1'b1) : r_acc;
        end else if (r_neg_q) begin
            o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            o_lo = w_prod_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// Execute-stage ALU: single-cycle ops complete in one cycle from IDLE;
// mult/div are handed to the iterative unit and hold off new requests.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_mdu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic [3:0]         w_opc;
    logic [2:0]         w_fn;
    logic               w_accept;
    logic               w_is_md;
    logic               w_dbz;
    logic               w_start;
    logic [WIDTH-1:0]   w_alu;
    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_ror_full;
    logic [2*WIDTH-1:0] w_rol_full;
    logic               w_md_done;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;
    state_t             w_state;

    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_zero;
    logic               r_sign;
    logic               r_out_valid;
    logic               r_dbz;

    assign w_opc    = bus.op[6:3];
    assign w_fn     = bus.op[2:0];
    assign w_accept = bus.in_valid && bus.in_ready;
    // funct 010/011 are mult/div in both the unsigned and signed groups
    assign w_is_md  = ((w_opc == OP_ALU0) || (w_opc == OP_ALU1)) && (w_fn[2:1] == 2'b01);
    assign w_dbz    = w_is_md && w_fn[0] && (bus.b == '0);
    assign w_start  = w_accept && w_is_md && !w_dbz;

    // Rotates via a doubled operand so amount 0 needs no special case
    assign w_sh       = bus.a[SHW-1:0];
    assign w_ror_full = {bus.b, bus.b} >> w_sh;
    assign w_rol_full = {bus.b, bus.b} << w_sh;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_is_div    (w_fn[0]),
        .i_is_signed (w_opc == OP_ALU1),
        .i_a         (bus.a),
        .i_b         (bus.b),
        .o_done      (w_md_done),
        .o_hi        (w_md_hi),
        .o_lo        (w_md_lo),
        .o_state     (w_state)
    );

    // Single-cycle result for every non-mult/div op
    always_comb begin
        w_alu = '0;
        case (w_opc)
            OP_ALU0: case (w_fn)
                F0_ADDU: w_alu = bus.a + bus.b;
                F0_SUBU: w_alu = bus.a - bus.b;
                F0_AND:  w_alu = bus.a & bus.b;
                F0_OR:   w_alu = bus.a | bus.b;
                F0_NOR:  w_alu = ~(bus.a | bus.b);
                F0_XOR:  w_alu = bus.a ^ bus.b;
                default: w_alu = '0;
            endcase
            OP_ALU1: case (w_fn)
                F1_ADD:   w_alu = bus.a + bus.b;
                F1_SUB:   w_alu = bus.a - bus.b;
                F1_SLT:   w_alu = WIDTH'($signed(bus.a) < $signed(bus.b));
                F1_SEQ:   w_alu = WIDTH'(bus.a == bus.b);
                F1_SLTU:  w_alu = WIDTH'(bus.a < bus.b);
                F1_PASSA: w_alu = bus.a;
                default:  w_alu = '0;
            endcase
            OP_ALU2: case (w_fn)
                F2_SHR:  w_alu = bus.b >> w_sh;
                F2_SHL:  w_alu = bus.b << w_sh;
                F2_ROR:  w_alu = w_ror_full[WIDTH-1:0];
                F2_ROL:  w_alu = w_rol_full[2*WIDTH-1:WIDTH];
                F2_SRA:  w_alu = $signed(bus.b) >>> w_sh;
                default: w_alu = '0;
            endcase
            OP_ADDI: w_alu = bus.a + bus.b;
            OP_SLTI: w_alu = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_BNEQ: w_alu = WIDTH'(bus.a != bus.b);
            OP_BGTZ: w_alu = WIDTH'(!bus.a[WIDTH-1] && (bus.a != '0));
            default: w_alu = bus.a + bus.b;
        endcase
    end

    // Output registers: one pulse per completed op, hi/lo only on mult/div done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_zero      <= 1'b1;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            if (w_md_done) begin
                r_result    <= '0;
                r_zero      <= 1'b1;
                r_sign      <= 1'b0;
                r_hi        <= w_md_hi;
                r_lo        <= w_md_lo;
                r_out_valid <= 1'b1;
            end else if (w_accept && !w_start) begin
                r_result    <= w_dbz ? '0 : w_alu;
                r_zero      <= w_dbz ? 1'b1 : (w_alu == '0);
                r_sign      <= w_dbz ? 1'b0 : w_alu[WIDTH-1];
                r_dbz       <= w_dbz;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign bus.in_ready    = (w_state == IDLE);
    assign bus.busy        = (w_state != IDLE);
    assign bus.state       = w_state;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.zero_flag   = r_zero;
    assign bus.sign_flag   = r_sign;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed and randomized checks of alu_mdu_seq against an arithmetic model.
module tb_alu_mdu_seq;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.WIDTH(W)) bus ();

  alu_mdu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic dbz, output logic md);
    int ua, ub, sa, sb, amt, p2;
    longint p;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    amt = ua % W;
    p2 = 1 << amt;
    r = '0;
    dbz = 1'b0;
    md = 1'b0;
    case (op[6:3])
      4'd0: case (op[2:0])
        3'd0: r = W'(ua + ub);
        3'd1: r = W'(ua - ub);
        3'd2: begin
          md = 1'b1;
          p = longint'(ua) * longint'(ub);
          m_hi = W'(p >> W);
          m_lo = W'(p);
        end
        3'd3: if (ub == 0) dbz = 1'b1;
              else begin md = 1'b1; m_lo = W'(ua / ub); m_hi = W'(ua % ub); end
        3'd4: r = a & b;
        3'd5: r = a | b;
        3'd6: r = ~(a | b);
        default: r = a ^ b;
      endcase
      4'd1: case (op[2:0])
        3'd0: r = W'(sa + sb);
        3'd1: r = W'(sa - sb);
        3'd2: begin
          md = 1'b1;
          p = longint'(sa) * longint'(sb);
          m_hi = W'(p >> W);
          m_lo = W'(p);
        end
        3'd3: if (sb == 0) dbz = 1'b1;
              else begin md = 1'b1; m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
        3'd4: r = W'(sa < sb);
        3'd5: r = W'(ua == ub);
        3'd6: r = W'(ua < ub);
        default: r = a;
      endcase
      4'd2: case (op[2:0])
        3'd0: r = W'(ub / p2);
        3'd1: r = W'(ub * p2);
        3'd2: r = W'(ub / p2 + (ub % p2) * (1 << (W - amt)));
        3'd3: r = W'(ub * p2 + ub / (1 << (W - amt)));
        3'd4: r = W'(sb >>> amt);
        default: r = '0;
      endcase
      4'd3: r = W'(ua + ub);
      4'd4: r = W'(sa < sb);
      4'd5: r = W'(ua != ub);
      4'd6: r = W'(sa > 0);
      default: r = W'(ua + ub);
    endcase
  endtask

  // Driver: issue one op (called at a negedge), wait for its completion, check it.
  task automatic run_op(input logic [6:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] er;
    logic edbz, emd;
    int lat, guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'(1));
    model(op, a, b, er, edbz, emd);
    exp_q.push_back(er);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, ":latency"}, 64'(lat), emd ? 64'(W + 2) : 64'(1));
    chk({tag, ":result"}, 64'(bus.result), 64'(exp_q.pop_front()));
    chk({tag, ":zero"}, 64'(bus.zero_flag), 64'(er == '0));
    chk({tag, ":sign"}, 64'(bus.sign_flag), 64'(er[W-1]));
    chk({tag, ":dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({tag, ":hi"}, 64'(bus.hi), 64'(m_hi));
    chk({tag, ":lo"}, 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rop;
    logic [W-1:0] ra, rb;
    int low_cnt, early_ov;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst:result", 64'(bus.result), 64'(0));
    chk("rst:hi", 64'(bus.hi), 64'(0));
    chk("rst:lo", 64'(bus.lo), 64'(0));
    chk("rst:zero", 64'(bus.zero_flag), 64'(1));
    chk("rst:sign", 64'(bus.sign_flag), 64'(0));
    chk("rst:out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst:dbz", 64'(bus.div_by_zero), 64'(0));
    chk("rst:in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst:busy", 64'(bus.busy), 64'(0));

    // addu wrap then back-to-back slt
    run_op(7'b0000_000, 16'hFFFF, 16'h0001, "addu_wrap");
    chk("addu_wrap:const", 64'(bus.result), 64'(0));
    run_op(7'b0001_100, 16'hFFFF, 16'h0001, "slt_b2b");
    chk("slt_b2b:const", 64'(bus.result), 64'(1));

    // multu with ignored requests while busy
    begin
      logic [W-1:0] er;
      logic edbz, emd;
      model(7'b0000_010, 16'hFFFF, 16'hFFFF, er, edbz, emd);
      bus.in_valid = 1'b1;
      bus.op = 7'b0000_010;
      bus.a = 16'hFFFF;
      bus.b = 16'hFFFF;
      @(posedge clk);
      low_cnt = 0;
      early_ov = 0;
      for (int i = 0; i < W + 1; i++) begin
        @(negedge clk);
        if (!bus.in_ready) low_cnt++;
        if (bus.out_valid) early_ov++;
        bus.op = 7'b0000_000;
        bus.a = W'($urandom_range(0, 255));
        bus.b = W'($urandom_range(0, 255));
        bus.in_valid = (i != W) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      chk("multu:ready_low", 64'(low_cnt), 64'(W + 1));
      chk("multu:early_ov", 64'(early_ov), 64'(0));
      @(negedge clk);
      chk("multu:out_valid", 64'(bus.out_valid), 64'(1));
      chk("multu:hi", 64'(bus.hi), 64'(m_hi));
      chk("multu:lo", 64'(bus.lo), 64'(m_lo));
      chk("multu:hi_const", 64'(bus.hi), 64'(16'hFFFE));
      chk("multu:lo_const", 64'(bus.lo), 64'(16'h0001));
      chk("multu:result", 64'(bus.result), 64'(0));
      chk("multu:zero", 64'(bus.zero_flag), 64'(1));
      @(negedge clk);
      chk("multu:no_extra", 64'(bus.out_valid), 64'(0));
    end

    // signed divides
    run_op(7'b0001_011, 16'hFFF9, 16'h0002, "div_neg");
    chk("div_neg:lo_const", 64'(bus.lo), 64'(16'hFFFD));
    chk("div_neg:hi_const", 64'(bus.hi), 64'(16'hFFFF));
    run_op(7'b0001_011, 16'h8000, 16'hFFFF, "div_min");
    chk("div_min:lo_const", 64'(bus.lo), 64'(16'h8000));
    chk("div_min:hi_const", 64'(bus.hi), 64'(16'h0000));

    // divide by zero keeps hi/lo
    run_op(7'b0001_010, 16'd3, 16'd5, "mult_pre");
    run_op(7'b0000_011, 16'd9, 16'd0, "divu_zero");
    chk("divu_zero:lo_const", 64'(bus.lo), 64'(16'h000F));
    chk("divu_zero:dbz_const", 64'(bus.div_by_zero), 64'(1));

    // shifts and rotates
    run_op(7'b0010_010, 16'd1, 16'h0001, "ror1");
    chk("ror1:const", 64'(bus.result), 64'(16'h8000));
    run_op(7'b0010_011, 16'd0, 16'h1234, "rol0");
    chk("rol0:const", 64'(bus.result), 64'(16'h1234));
    run_op(7'b0010_100, 16'd4, 16'h8000, "sra4");
    chk("sra4:const", 64'(bus.result), 64'(16'hF800));
    run_op(7'b0010_001, 16'h0013, 16'h0001, "shl_mask");
    chk("shl_mask:const", 64'(bus.result), 64'(16'h0008));

    // reset during RUN
    bus.in_valid = 1'b1;
    bus.op = 7'b0001_010;
    bus.a = 16'h1234;
    bus.b = 16'h0567;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("abort:in_ready", 64'(bus.in_ready), 64'(1));
    chk("abort:hi", 64'(bus.hi), 64'(0));
    chk("abort:lo", 64'(bus.lo), 64'(0));
    early_ov = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (bus.out_valid) early_ov++;
      @(negedge clk);
    end
    chk("abort:no_out_valid", 64'(early_ov), 64'(0));
    run_op(7'b0000_000, 16'd2, 16'd3, "addu_after_abort");
    chk("addu_after_abort:const", 64'(bus.result), 64'(5));

    // randomized ops
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        rop = {3'b000, 1'($urandom_range(0, 1)), 2'b01, 1'($urandom_range(0, 1))};
      else
        rop = 7'($urandom_range(0, 127));
      ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
      run_op(rop, ra, rb, $sformatf("rand%0d_op%0h", n, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised successor to the single-cycle datapath ALU. It executes the same 7-bit {opcode, funct} operation set at WIDTH bits, with registered outputs and a valid/ready handshake. Multiply and divide run on an iterative radix-2 unit over WIDTH cycles instead of a combinational array. HI/LO become architectural registers that hold their value between operations. The block sits in the execute stage; the control unit stalls the pipeline on in_ready low.

Parameters:
WIDTH, 16, datapath width in bits; any value ≥ 8 that is a power of 2.
SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation request
in_ready  out  1  block can accept; high only in IDLE
op  in  7  {opcode[3:0], funct[2:0]}
a  in  WIDTH  operand A (rs; shift amount for ALU2)
b  in  WIDTH  operand B (rt / immediate)
out_valid  out  1  one-cycle pulse: result/flags/hi/lo updated
result  out  WIDTH  registered result
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
zero_flag  out  1  registered (result == 0)
sign_flag  out  1  registered result[WIDTH-1]
div_by_zero  out  1  one-cycle pulse with out_valid on div/divu with b == 0
busy  out  1  multiply/divide in progress (= !in_ready)

Behaviour:
- Reset: state IDLE. result, hi, lo = 0; zero_flag = 1; sign_flag, out_valid, div_by_zero = 0; in_ready = 1. Reset mid-operation aborts the operation with no out_valid.
- Accept: an operation is accepted at an edge where in_valid && in_ready. Op/a/b are sampled only at that edge.
- Single-cycle ops: every op except mult, multu, div, divu. out_valid pulses in the cycle after the accept edge. The block stays in IDLE, so back-to-back issue gives one op per cycle.
- ALU0 (unsigned): addu, subu, multu, divu, and, or, nor, xor. Add/sub wrap modulo 2^WIDTH.
- ALU1 (signed): add, sub, mult, div, slt, seq, sltu, pass-A (jr).
- ALU2 (shift/rotate): amount = a[SHW-1:0] applied to b.
  - 000 shr (logical), 001 shl, 010 ror, 011 rol.
  - 100 sra (new): arithmetic right shift.
  - 101–111 give result 0.
  - Rotate by 0 returns b.
- Other opcodes: 0011 addi, 0100 slti, 0101 a != b, 0110 signed a > 0. All remaining opcodes, including 1000/1001, give a + b.
- Compare ops produce 0 or 1, zero-extended to WIDTH.
- Mult/div FSM: IDLE → RUN (WIDTH cycles, one bit per cycle) → FIX (1 cycle, sign correction) → IDLE.
  - out_valid pulses WIDTH+2 cycles after the accept edge.
  - in_ready = 0 from the cycle after accept through FIX.
- Multiply: mult/multu produce a 2·WIDTH product; {hi, lo} = product. Signed mult takes magnitudes, then negates the product in FIX if the operand signs differ.
- Divide: div/divu use restoring division on magnitudes.
  - lo = quotient, truncated toward zero; hi = remainder, carrying the dividend's sign.
  - Signed MIN / -1 gives lo = MIN, hi = 0 (no trap).
- Divide by zero: detected at accept. Completes as a single-cycle op: div_by_zero = 1, hi/lo unchanged, result = 0.
- Result and flags on mult/div completion: result = 0, zero_flag = 1, sign_flag = 0. hi/lo change only on mult/div completion.
- Flags: zero_flag and sign_flag are updated with every out_valid and held otherwise.
- in_valid while busy: ignored (not queued).

Decomposition:
- Package alu_pkg: opcode constants (OP_ALU0, OP_ALU1, OP_ALU2, OP_ADDI, OP_SLTI, OP_BNEQ, OP_BGTZ, OP_LH, OP_SH), funct constants per group, and the state enum {IDLE, RUN, FIX}.
- Sub-module alu_muldiv_iter: iterative shift-add/restoring unit.
  - Inputs: start, is_div, is_signed, a, b.
  - Outputs: done, hi, lo.
- The top level holds the single-cycle logic, output registers and the handshake.

Test Plan (WIDTH=16):
1. addu a=0xFFFF, b=0x0001 → one cycle later out_valid=1, result=0x0000, zero_flag=1. Back-to-back slt a=0xFFFF, b=0x0001 → result=1 on the next cycle.
2. multu a=0xFFFF, b=0xFFFF → in_ready low for 17 cycles; out_valid 18 cycles after accept with hi=0xFFFE, lo=0x0001. in_valid pulses during busy are ignored.
3. div a=0xFFF9 (−7), b=0x0002 → lo=0xFFFD, hi=0xFFFF. Then div a=0x8000, b=0xFFFF → lo=0x8000, hi=0x0000.
4. Preload hi/lo via mult 3×5 (hi=0, lo=0x000F), then divu a=9, b=0 → out_valid and div_by_zero one cycle later; hi=0x0000 and lo=0x000F retained.
5. ror b=0x0001, a=1 → 0x8000. rol b=0x1234, a=0 → 0x1234. sra b=0x8000, a=4 → 0xF800 with sign_flag=1. shl b=0x0001, a=0x0013 → 0x0008 (a[3:0]=3).
6. Assert rst during RUN of a mult → no out_valid. Next cycle hi=lo=0 and in_ready=1; a following addu 2+3 returns 5.
